// File: rtl/spi_lab_pkg.sv
// Shared command codes, reply constants and controller state encoding for the
// SPI command controller.
package spi_lab_pkg;

    localparam logic [7:0] CMD_FEED0 = 8'h00;
    localparam logic [7:0] CMD_FEED1 = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'hFF;
    localparam logic [7:0] ERR_REPLY = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_FEED   = 2'd2,
        ST_REPLY  = 2'd3
    } ctrl_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command byte FIFO. DEPTH must be a power of two, so the pointers wrap naturally.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: queues received bytes, decodes them one at a time and
// either feeds a bit to the controlled state machine or returns a reply byte.
module spi_cmd_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         FEED_HOLD  = 4,
    parameter logic [7:0] ERR_REPLY  = spi_lab_pkg::ERR_REPLY
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_RX_DV,
    input  logic [7:0]               i_RX_Byte,
    input  logic [7:0]               i_State,
    output logic                     o_TX_DV,
    output logic [7:0]               o_TX_Byte,
    output logic                     o_Feed_Valid,
    output logic                     o_Feed_Bit,
    output logic [7:0]               o_Err_Cnt,
    output logic                     o_Overflow,
    output logic                     o_Busy,
    output spi_lab_pkg::ctrl_state_t dbg_state
);

    import spi_lab_pkg::*;

    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  HOLD_LAST = 4'(FEED_HOLD - 1);

    ctrl_state_t      state;
    logic [7:0]       cmd;
    logic [3:0]       hold_cnt;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic [CNT_W-1:0] fifo_count;
    logic             queue_busy_next;

    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign dbg_state = state;
    // Occupancy after this edge when the controller is not popping.
    assign queue_busy_next = (fifo_count != '0) || i_RX_DV;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .push    (i_RX_DV),
        .pop     (fifo_pop),
        .wr_data (i_RX_Byte),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= ST_IDLE;
            cmd          <= '0;
            hold_cnt     <= '0;
            o_TX_DV      <= 1'b0;
            o_TX_Byte    <= '0;
            o_Feed_Valid <= 1'b0;
            o_Feed_Bit   <= 1'b0;
            o_Err_Cnt    <= '0;
            o_Overflow   <= 1'b0;
            o_Busy       <= 1'b0;
        end else begin
            if (i_RX_DV && fifo_full && !fifo_pop) o_Overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd    <= fifo_rd_data;
                        state  <= ST_DECODE;
                        o_Busy <= 1'b1;
                    end else begin
                        o_Busy <= queue_busy_next;
                    end
                end
                ST_DECODE: begin
                    case (cmd)
                        CMD_FEED0, CMD_FEED1: begin
                            state        <= ST_FEED;
                            o_Feed_Valid <= 1'b1;
                            o_Feed_Bit   <= cmd[0];
                            hold_cnt     <= HOLD_LAST;
                        end
                        CMD_READ: begin
                            state     <= ST_REPLY;
                            o_TX_DV   <= 1'b1;
                            o_TX_Byte <= i_State;
                        end
                        default: begin
                            state     <= ST_REPLY;
                            o_TX_DV   <= 1'b1;
                            o_TX_Byte <= ERR_REPLY;
                            o_Err_Cnt <= sat_inc8(o_Err_Cnt);
                        end
                    endcase
                end
                ST_FEED: begin
                    if (hold_cnt == '0) begin
                        o_Feed_Valid <= 1'b0;
                        state        <= ST_IDLE;
                        o_Busy       <= queue_busy_next;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                ST_REPLY: begin
                    o_TX_DV <= 1'b0;
                    state   <= ST_IDLE;
                    o_Busy  <= queue_busy_next;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
